// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci calculator / index finder pair.
// Both blocks use the same state encoding and the same index convention
// so that one can decode what the other produces.
package fib_pkg;

   // Control states shared by the calculator and the index finder
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } fib_state_t;

   // Default datapath sizing: F(24)=46368 is the largest term in 16 bits
   localparam int FIB_W       = 16;
   localparam int FIB_IDX_W   = 5;
   localparam int FIB_MAX_IDX = 24;

   // Index convention: F(1)=F(2)=1; iteration starts at prev=F(2), cur=F(3)
   localparam int FIB_F1_VAL         = 1;
   localparam int FIB_F1_IDX         = 1;
   localparam int FIB_ITER_PREV      = 1;
   localparam int FIB_ITER_CUR       = 2;
   localparam int FIB_ITER_START_IDX = 3;

endpackage : fib_pkg

// File: rtl/fibonacci_index_finder_if.sv
// Request/result bundle of the index finder: a four-phase level handshake
// (begin_search / done) carrying the value to decode and its result.
interface fibonacci_index_finder_if
   import fib_pkg::*;
#(
   parameter int WIDTH = FIB_W,
   parameter int IDX_W = FIB_IDX_W
);

   logic [WIDTH-1:0] value_in;
   logic             begin_search;
   logic             done;
   logic             is_fib;
   logic [IDX_W-1:0] index_out;

   // Requester side: drives the value and the request level
   modport master (
      output value_in,
      output begin_search,
      input  done,
      input  is_fib,
      input  index_out
   );

   // Decoder side: samples the request, returns the result
   modport slave (
      input  value_in,
      input  begin_search,
      output done,
      output is_fib,
      output index_out
   );

endinterface : fibonacci_index_finder_if

// File: rtl/fib_step.sv
// One Fibonacci iteration: (prev, cur) -> (cur, cur+prev).
// The sum is formed one bit wider than the terms; the extra bit flags a
// term that no longer fits in WIDTH bits.  Purely combinational so the
// calculator and the index finder advance through the sequence identically.
module fib_step
   import fib_pkg::*;
#(
   parameter int WIDTH = FIB_W
) (
   input  logic [WIDTH-1:0] prev_i,
   input  logic [WIDTH-1:0] cur_i,
   output logic [WIDTH-1:0] next_prev_o,
   output logic [WIDTH-1:0] next_cur_o,
   output logic             overflow_o
);

   logic [WIDTH:0] sum_s;

   assign sum_s       = {1'b0, prev_i} + {1'b0, cur_i};
   assign next_prev_o = cur_i;
   assign next_cur_o  = sum_s[WIDTH-1:0];
   assign overflow_o  = sum_s[WIDTH];

endmodule : fib_step

// File: rtl/fibonacci_index_finder.sv
// Fibonacci index finder: decodes a value into its Fibonacci index n
// (F(1)=F(2)=1), walking the sequence one term per clock.  On a miss it
// reports the index of the largest term below the value.  Results are
// registered and held until the requester drops begin_search.
module fibonacci_index_finder
   import fib_pkg::*;
#(
   parameter int WIDTH = FIB_W,
   parameter int IDX_W = FIB_IDX_W
) (
   input  logic                     clk,
   input  logic                     reset,
   fibonacci_index_finder_if.slave  bus
);

   fib_state_t       state_q,  state_d;
   logic [WIDTH-1:0] target_q, target_d;
   logic [WIDTH-1:0] prev_q,   prev_d;
   logic [WIDTH-1:0] cur_q,    cur_d;
   logic [IDX_W-1:0] idx_q,    idx_d;
   logic             done_q,   done_d;
   logic             is_fib_q, is_fib_d;
   logic [IDX_W-1:0] index_q,  index_d;

   logic [WIDTH-1:0] step_prev_s;
   logic [WIDTH-1:0] step_cur_s;
   logic             step_ovf_s;

   fib_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .prev_i      (prev_q),
      .cur_i       (cur_q),
      .next_prev_o (step_prev_s),
      .next_cur_o  (step_cur_s),
      .overflow_o  (step_ovf_s)
   );

   // Next-state and result logic for the IDLE/SEARCH/DONE controller
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      prev_d   = prev_q;
      cur_d    = cur_q;
      idx_d    = idx_q;
      is_fib_d = is_fib_q;
      index_d  = index_q;

      case (state_q)
         IDLE: begin
            if (bus.begin_search) begin
               target_d = bus.value_in;
               if (bus.value_in == {WIDTH{1'b0}}) begin
                  // Zero is not a Fibonacci number and has no floor term
                  state_d  = DONE;
                  is_fib_d = 1'b0;
                  index_d  = {IDX_W{1'b0}};
               end else if (bus.value_in == WIDTH'(FIB_F1_VAL)) begin
                  // Value 1 is both F(1) and F(2); report the lower index
                  state_d  = DONE;
                  is_fib_d = 1'b1;
                  index_d  = IDX_W'(FIB_F1_IDX);
               end else begin
                  state_d = SEARCH;
                  prev_d  = WIDTH'(FIB_ITER_PREV);
                  cur_d   = WIDTH'(FIB_ITER_CUR);
                  idx_d   = IDX_W'(FIB_ITER_START_IDX);
               end
            end else begin
               state_d = IDLE;
            end
         end

         SEARCH: begin
            if (cur_q == target_q) begin
               state_d  = DONE;
               is_fib_d = 1'b1;
               index_d  = idx_q;
            end else if (cur_q > target_q) begin
               // Overshot: the previous term is the floor
               state_d  = DONE;
               is_fib_d = 1'b0;
               index_d  = idx_q - IDX_W'(1);
            end else if (step_ovf_s) begin
               // Target lies above the largest representable term
               state_d  = DONE;
               is_fib_d = 1'b0;
               index_d  = idx_q;
            end else begin
               prev_d = step_prev_s;
               cur_d  = step_cur_s;
               idx_d  = idx_q + IDX_W'(1);
            end
         end

         DONE: begin
            // Require the request to drop before another search can start
            if (!bus.begin_search) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      done_d = (state_d == DONE);
   end

   // State, datapath and result registers; reset aborts any search in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         target_q <= {WIDTH{1'b0}};
         prev_q   <= {WIDTH{1'b0}};
         cur_q    <= {WIDTH{1'b0}};
         idx_q    <= {IDX_W{1'b0}};
         done_q   <= 1'b0;
         is_fib_q <= 1'b0;
         index_q  <= {IDX_W{1'b0}};
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         prev_q   <= prev_d;
         cur_q    <= cur_d;
         idx_q    <= idx_d;
         done_q   <= done_d;
         is_fib_q <= is_fib_d;
         index_q  <= index_d;
      end
   end

   assign bus.done      = done_q;
   assign bus.is_fib    = is_fib_q;
   assign bus.index_out = index_q;

endmodule : fibonacci_index_finder

// File: tb/tb_fibonacci_index_finder.sv
// Directed self-checking bench for fibonacci_index_finder.
module tb_fibonacci_index_finder;

   localparam int WIDTH = 16;
   localparam int IDX_W = 5;
   localparam int MAX_WAIT = 40;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   fibonacci_index_finder_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bif ();

   fibonacci_index_finder #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   // Free-running 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Called just after E0: waits (bounded) for done, checks latency and result
   task automatic measure(input string tag, input bit exp_fib, input int exp_idx, input int exp_lat);
      int lat;
      lat = 0;
      while (bif.done !== 1'b1 && lat < MAX_WAIT) begin
         @(posedge clk); #1;
         lat++;
      end
      check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check_eq({tag, "_isfib"}, 32'(bif.is_fib), 32'(exp_fib));
      check_eq({tag, "_idx"}, 32'(bif.index_out), 32'(exp_idx));
   endtask

   // Raise the request and measure; request left high
   task automatic search(input string tag, input logic [15:0] v, input bit exp_fib,
                         input int exp_idx, input int exp_lat);
      bif.value_in     = v;
      bif.begin_search = 1'b1;
      @(posedge clk); #1;
      measure(tag, exp_fib, exp_idx, exp_lat);
   endtask

   // Drop the request; done must fall on the next edge
   task automatic release_req(input string tag);
      bif.begin_search = 1'b0;
      @(posedge clk); #1;
      check_eq({tag, "_done_fall"}, 32'(bif.done), 32'd0);
   endtask

   logic [15:0] fib_tab [1:24];
   logic [IDX_W-1:0] held_idx;

   initial begin
      checks = 0;
      errors = 0;
      reset            = 1'b0;
      bif.value_in     = 16'd5;
      bif.begin_search = 1'b1;

      // Reset held with a live request: outputs stay cleared
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_eq("rst_done", 32'(bif.done), 32'd0);
         check_eq("rst_isfib", 32'(bif.is_fib), 32'd0);
         check_eq("rst_idx", 32'(bif.index_out), 32'd0);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      measure("post_rst_5", 1'b1, 5, 3);
      release_req("post_rst_5");

      // Boundary and miss cases
      search("v46368", 16'd46368, 1'b1, 24, 22); release_req("v46368");
      search("v1", 16'd1, 1'b1, 1, 0);           release_req("v1");
      search("v0", 16'd0, 1'b0, 0, 0);           release_req("v0");
      search("v100", 16'd100, 1'b0, 11, 10);     release_req("v100");
      search("v4", 16'd4, 1'b0, 4, 3);           release_req("v4");
      search("v2", 16'd2, 1'b1, 3, 1);           release_req("v2");
      search("v65535", 16'd65535, 1'b0, 24, 22);

      // Request held through DONE: no restart, outputs stable
      held_idx = bif.index_out;
      bif.value_in = 16'd3;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check_eq("hold_done", 32'(bif.done), 32'd1);
         check_eq("hold_idx", 32'(bif.index_out), 32'(held_idx));
      end
      release_req("hold");
      search("v21", 16'd21, 1'b1, 8, 6); release_req("v21");

      // Value changed after E0 is ignored
      bif.value_in     = 16'd233;
      bif.begin_search = 1'b1;
      @(posedge clk); #1;
      bif.value_in = 16'd5;
      measure("v233_chg", 1'b1, 13, 11);
      release_req("v233_chg");

      // Async reset mid-search clears outputs at once
      bif.value_in     = 16'd28657;
      bif.begin_search = 1'b1;
      @(posedge clk); #1;
      repeat (3) begin @(posedge clk); #1; end
      #2 reset = 1'b0;
      #1;
      check_eq("abort_done", 32'(bif.done), 32'd0);
      check_eq("abort_isfib", 32'(bif.is_fib), 32'd0);
      check_eq("abort_idx", 32'(bif.index_out), 32'd0);
      bif.begin_search = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (25) begin
         @(posedge clk); #1;
         check_eq("abort_no_done", 32'(bif.done), 32'd0);
      end
      search("v13", 16'd13, 1'b1, 7, 5); release_req("v13");

      // Loopback: decode every representable term F(1)..F(24)
      fib_tab[1] = 16'd1;
      fib_tab[2] = 16'd1;
      for (int n = 3; n <= 24; n++) fib_tab[n] = fib_tab[n-1] + fib_tab[n-2];
      for (int n = 1; n <= 24; n++) begin
         search($sformatf("loop_n%0d", n), fib_tab[n], 1'b1,
                (n == 2) ? 1 : n, (n <= 2) ? 0 : n - 2);
         release_req($sformatf("loop_n%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_fibonacci_index_finder
